// File: rtl/ftdl_arb_pkg.sv
// Shared constants and state encoding for the activation-buffer write arbiter.
package ftdl_arb_pkg;

  localparam int unsigned NumReqDefault = 4;
  localparam int unsigned BlenWDefault  = 16;

  typedef enum logic [0:0] {
    StIdle,
    StXfer
  } arb_state_e;

endpackage

// File: rtl/rr_arb_pick.sv
// Combinational round-robin picker: first set bit of req at or after start, wrapping.
module rr_arb_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   start,
  output logic               any,
  output logic [IDX_W-1:0]   index
);

  int unsigned cand;

  always_comb begin
    any   = 1'b0;
    index = '0;
    cand  = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = (32'(start) + i) % NUM_REQ;
      if (!any && req[cand[IDX_W-1:0]]) begin
        any   = 1'b1;
        index = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/actbuf_wr_arb.sv
// Grants one super-block controller at a time a burst of the shared activation write stream.
module actbuf_wr_arb
  import ftdl_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = NumReqDefault,
  parameter int unsigned BLEN_W  = BlenWDefault
) (
  input  logic                       clk_l,
  input  logic                       rst,
  input  logic                       cfg_en,
  input  logic [BLEN_W-1:0]          cfg_blen,
  input  logic [NUM_REQ-1:0]         wr_req,
  input  logic                       src_vld,
  output logic                       src_rdy,
  output logic [NUM_REQ-1:0]         wr_vld,
  output logic [$clog2(NUM_REQ)-1:0] gnt_id,
  output logic                       busy,
  output logic                       abort
);

  localparam int unsigned GW = $clog2(NUM_REQ);
  localparam logic [BLEN_W-1:0] BlenOne = BLEN_W'(1);
  localparam logic [GW-1:0]     GidOne  = GW'(1);
  localparam logic [GW-1:0]     GidLast = GW'(NUM_REQ - 1);

  arb_state_e        state_q, state_d;
  logic [GW-1:0]     gnt_q, gnt_d;
  logic [GW-1:0]     rr_q, rr_d;
  logic [BLEN_W-1:0] cnt_q, cnt_d;
  logic [BLEN_W-1:0] blen_q, blen_d;
  logic [BLEN_W-1:0] shadow_q, shadow_d;
  logic              abort_q, abort_d;

  logic              pick_any;
  logic [GW-1:0]     pick_idx;
  logic [GW-1:0]     gnt_inc;
  logic              beat;
  logic              last_beat;

  rr_arb_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (GW)
  ) u_pick (
    .req   (wr_req),
    .start (rr_q),
    .any   (pick_any),
    .index (pick_idx)
  );

  assign busy      = (state_q == StXfer);
  assign src_rdy   = busy;
  assign gnt_id    = gnt_q;
  assign abort     = abort_q;
  assign beat      = src_vld & src_rdy;
  assign last_beat = beat && (cnt_q == blen_q - BlenOne);
  assign gnt_inc   = (gnt_q == GidLast) ? '0 : gnt_q + GidOne;

  always_comb begin
    wr_vld = '0;
    if (busy) begin
      wr_vld[gnt_q] = beat;
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    rr_d     = rr_q;
    cnt_d    = cnt_q;
    blen_d   = blen_q;
    abort_d  = 1'b0;
    shadow_d = cfg_en ? cfg_blen : shadow_q;
    unique case (state_q)
      StIdle: begin
        // The grant edge also loads the shadow, so both must be nonzero to avoid a zero-length burst.
        blen_d = shadow_q;
        if (pick_any && (blen_q != '0) && (shadow_q != '0)) begin
          state_d = StXfer;
          gnt_d   = pick_idx;
          cnt_d   = '0;
        end
      end
      StXfer: begin
        if (beat) begin
          cnt_d = cnt_q + BlenOne;
        end
        // A request drop coinciding with the last beat completes normally.
        if (last_beat) begin
          state_d = StIdle;
          rr_d    = gnt_inc;
        end else if (!wr_req[gnt_q]) begin
          state_d = StIdle;
          rr_d    = gnt_inc;
          abort_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_l or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      gnt_q    <= '0;
      rr_q     <= '0;
      cnt_q    <= '0;
      blen_q   <= '0;
      shadow_q <= '0;
      abort_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      rr_q     <= rr_d;
      cnt_q    <= cnt_d;
      blen_q   <= blen_d;
      shadow_q <= shadow_d;
      abort_q  <= abort_d;
    end
  end

endmodule

// File: tb/tb_actbuf_wr_arb.sv
// Directed self-checking bench for actbuf_wr_arb with NUM_REQ=4, BLEN_W=16.
module tb_actbuf_wr_arb;

  logic        clk_l = 1'b0;
  logic        rst   = 1'b1;
  logic        cfg_en = 1'b0;
  logic [15:0] cfg_blen = '0;
  logic [3:0]  wr_req = '0;
  logic        src_vld = 1'b0;
  logic        src_rdy;
  logic [3:0]  wr_vld;
  logic [1:0]  gnt_id;
  logic        busy;
  logic        abort;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_l = ~clk_l;

  actbuf_wr_arb #(
    .NUM_REQ (4),
    .BLEN_W  (16)
  ) dut (
    .clk_l    (clk_l),
    .rst      (rst),
    .cfg_en   (cfg_en),
    .cfg_blen (cfg_blen),
    .wr_req   (wr_req),
    .src_vld  (src_vld),
    .src_rdy  (src_rdy),
    .wr_vld   (wr_vld),
    .gnt_id   (gnt_id),
    .busy     (busy),
    .abort    (abort)
  );

  task automatic tick();
    @(posedge clk_l);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; cfg_en = 1'b0; cfg_blen = '0; wr_req = '0; src_vld = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic load_blen(input logic [15:0] b);
    cfg_en = 1'b1; cfg_blen = b;
    tick();
    cfg_en = 1'b0;
    tick(); tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_req = '0; src_vld = 1'b0;
    #1;
    n_checks++;
    if ({busy, src_rdy, wr_vld, abort, gnt_id} !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%b exp=%b", {busy, src_rdy, wr_vld, abort, gnt_id}, 9'b0);
    end
    tick(); tick();
    rst = 1'b0;
    wr_req = 4'b1111; src_vld = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++;
      if ({busy, wr_vld} !== 5'b0) begin
        n_fail++;
        $display("FAIL reset_no_cfg_grant cyc=%0d got=%b exp=%b", c, {busy, wr_vld}, 5'b0);
      end
    end
  endtask

  task automatic test_basic();
    do_reset();
    load_blen(16'd4);
    wr_req = 4'b0001; src_vld = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_latency got=%b exp=0", busy);
    end
    tick();
    for (int k = 0; k < 4; k++) begin
      if (k == 3) wr_req = 4'b0000;
      #1;
      n_checks++;
      if ({busy, src_rdy, gnt_id, wr_vld, abort} !== {1'b1, 1'b1, 2'd0, 4'b0001, 1'b0}) begin
        n_fail++;
        $display("FAIL basic_beat k=%0d got=%b exp=%b", k, {busy, src_rdy, gnt_id, wr_vld, abort},
                 {1'b1, 1'b1, 2'd0, 4'b0001, 1'b0});
      end
      tick();
    end
    #1;
    n_checks++;
    if ({busy, src_rdy, wr_vld, abort} !== 7'b0) begin
      n_fail++;
      $display("FAIL basic_end got=%b exp=%b", {busy, src_rdy, wr_vld, abort}, 7'b0);
    end
  endtask

  task automatic test_round_robin();
    int exp_g [11];
    logic [3:0] oh;
    exp_g = '{0, 0, -1, 1, 1, -1, 3, 3, -1, 0, 0};
    do_reset();
    load_blen(16'd2);
    wr_req = 4'b1011; src_vld = 1'b1;
    tick();
    for (int c = 0; c < 11; c++) begin
      #1;
      n_checks++;
      if (exp_g[c] < 0) begin
        if ({busy, wr_vld} !== 5'b0) begin
          n_fail++;
          $display("FAIL rr_idle_gap cyc=%0d got=%b exp=%b", c, {busy, wr_vld}, 5'b0);
        end
      end else begin
        oh = 4'b0001 << exp_g[c];
        if ({busy, gnt_id, wr_vld} !== {1'b1, 2'(exp_g[c]), oh}) begin
          n_fail++;
          $display("FAIL rr_grant cyc=%0d got=%b exp=%b", c, {busy, gnt_id, wr_vld},
                   {1'b1, 2'(exp_g[c]), oh});
        end
      end
      if (c == 10) wr_req = 4'b0000;
      tick();
    end
    #1;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rr_final_idle got=%b exp=0", busy);
    end
  endtask

  task automatic test_stall();
    logic pat [5];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    do_reset();
    load_blen(16'd3);
    wr_req = 4'b0001; src_vld = 1'b0;
    tick();
    for (int c = 0; c < 5; c++) begin
      src_vld = pat[c];
      if (c == 4) wr_req = 4'b0000;
      #1;
      n_checks++;
      if ({busy, src_rdy, wr_vld} !== {1'b1, 1'b1, pat[c] ? 4'b0001 : 4'b0000}) begin
        n_fail++;
        $display("FAIL stall_cycle cyc=%0d got=%b exp=%b", c + 1, {busy, src_rdy, wr_vld},
                 {1'b1, 1'b1, pat[c] ? 4'b0001 : 4'b0000});
      end
      tick();
    end
    src_vld = 1'b0;
    #1;
    n_checks++;
    if ({busy, abort} !== 2'b00) begin
      n_fail++;
      $display("FAIL stall_end got=%b exp=00", {busy, abort});
    end
  endtask

  task automatic test_abort();
    int strobes;
    strobes = 0;
    do_reset();
    load_blen(16'd8);
    wr_req = 4'b0100; src_vld = 1'b1;
    tick();
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if ({busy, gnt_id, wr_vld} !== {1'b1, 2'd2, 4'b0100}) begin
        n_fail++;
        $display("FAIL abort_beat cyc=%0d got=%b exp=%b", c, {busy, gnt_id, wr_vld},
                 {1'b1, 2'd2, 4'b0100});
      end
      if (wr_vld != 4'b0) strobes++;
      tick();
    end
    wr_req = 4'b0000; src_vld = 1'b0;
    #1;
    n_checks++;
    if ({busy, wr_vld, abort} !== {1'b1, 4'b0000, 1'b0}) begin
      n_fail++;
      $display("FAIL abort_drop_cycle got=%b exp=%b", {busy, wr_vld, abort}, 6'b100000);
    end
    if (wr_vld != 4'b0) strobes++;
    tick();
    wr_req = 4'b1111; src_vld = 1'b1;
    #1;
    n_checks++;
    if ({busy, src_rdy, wr_vld, abort} !== {1'b0, 1'b0, 4'b0000, 1'b1}) begin
      n_fail++;
      $display("FAIL abort_pulse got=%b exp=%b", {busy, src_rdy, wr_vld, abort}, 7'b0000001);
    end
    if (wr_vld != 4'b0) strobes++;
    tick();
    #1;
    n_checks++;
    if ({busy, gnt_id, abort} !== {1'b1, 2'd3, 1'b0}) begin
      n_fail++;
      $display("FAIL abort_rr_next got=%b exp=%b", {busy, gnt_id, abort}, 4'b1110);
    end
    n_checks++;
    if (strobes !== 3) begin
      n_fail++;
      $display("FAIL abort_strobe_count got=%0d exp=3", strobes);
    end
    wr_req = 4'b0000;
    tick();
  endtask

  task automatic test_reconfig();
    logic exp_b [9];
    int strobes;
    exp_b = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    strobes = 0;
    do_reset();
    load_blen(16'd2);
    wr_req = 4'b0001; src_vld = 1'b1;
    tick();
    for (int c = 0; c < 9; c++) begin
      if (c == 0) begin cfg_en = 1'b1; cfg_blen = 16'd5; end
      if (c == 1) cfg_en = 1'b0;
      #1;
      n_checks++;
      if ({busy, wr_vld} !== {exp_b[c], exp_b[c] ? 4'b0001 : 4'b0000}) begin
        n_fail++;
        $display("FAIL reconfig_cycle cyc=%0d got=%b exp=%b", c + 1, {busy, wr_vld},
                 {exp_b[c], exp_b[c] ? 4'b0001 : 4'b0000});
      end
      if (wr_vld != 4'b0) strobes++;
      if (c == 7) wr_req = 4'b0000;
      tick();
    end
    n_checks++;
    if (strobes !== 7) begin
      n_fail++;
      $display("FAIL reconfig_strobe_count got=%0d exp=7", strobes);
    end
    cfg_en = 1'b1; cfg_blen = 16'd0;
    tick();
    cfg_en = 1'b0;
    tick(); tick();
    wr_req = 4'b1111;
    for (int c = 0; c < 6; c++) begin
      #1;
      n_checks++;
      if ({busy, wr_vld} !== 5'b0) begin
        n_fail++;
        $display("FAIL zero_len_no_grant cyc=%0d got=%b exp=%b", c, {busy, wr_vld}, 5'b0);
      end
      tick();
    end
    wr_req = 4'b0000;
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    load_blen(16'd4);
    wr_req = 4'b0001; src_vld = 1'b1;
    tick();
    tick();
    #1;
    n_checks++;
    if ({busy, wr_vld} !== {1'b1, 4'b0001}) begin
      n_fail++;
      $display("FAIL rstmid_beat2 got=%b exp=%b", {busy, wr_vld}, 5'b10001);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({busy, src_rdy, wr_vld, abort, gnt_id} !== 9'b0) begin
      n_fail++;
      $display("FAIL rstmid_async_clear got=%b exp=%b", {busy, src_rdy, wr_vld, abort, gnt_id}, 9'b0);
    end
    tick();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_checks++;
      if ({busy, abort} !== 2'b00) begin
        n_fail++;
        $display("FAIL rstmid_no_grant cyc=%0d got=%b exp=00", c, {busy, abort});
      end
      tick();
    end
    cfg_en = 1'b1; cfg_blen = 16'd1;
    #1;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_cfg_cycle got=%b exp=0", busy);
    end
    tick();
    cfg_en = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_shadow_cycle got=%b exp=0", busy);
    end
    tick();
    #1;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_load_cycle got=%b exp=0", busy);
    end
    tick();
    wr_req = 4'b0000;
    #1;
    n_checks++;
    if ({busy, gnt_id, wr_vld} !== {1'b1, 2'd0, 4'b0001}) begin
      n_fail++;
      $display("FAIL rstmid_regrant got=%b exp=%b", {busy, gnt_id, wr_vld}, 7'b1000001);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_stall();
    test_abort();
    test_reconfig();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
